// File: rtl/spatz_boot_sequencer.sv
// spatz_boot_sequencer: waits a settle time, writes the entry point to boot-control over reqrsp, then pulses debug_req to wake all cores
module spatz_boot_sequencer #(
   parameter int unsigned AddrWidth = 48,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned NumCores = 2,
   parameter logic [AddrWidth-1:0] BootCtrlAddr = '0,
   parameter int unsigned WaitCycles = 1000,
   parameter int unsigned PulseCycles = 1,
   parameter int unsigned MaxRetries = 2,
   parameter int unsigned RespTimeout = 4096
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [31:0]            entry_point_i,
   output logic [AddrWidth-1:0]   q_addr_o,
   output logic [DataWidth-1:0]   q_data_o,
   output logic [DataWidth/8-1:0] q_strb_o,
   output logic                   q_write_o,
   output logic                   q_valid_o,
   input  logic                   q_ready_i,
   input  logic                   p_error_i,
   input  logic                   p_valid_i,
   output logic                   p_ready_o,
   output logic [NumCores-1:0]    debug_req_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   error_o
);
   localparam int unsigned M0 = WaitCycles > PulseCycles ? WaitCycles : PulseCycles;
   localparam int unsigned CntMax = M0 > RespTimeout ? M0 : RespTimeout;
   localparam int unsigned CntW = $clog2(CntMax + 1);
   localparam int unsigned RetW = MaxRetries > 0 ? $clog2(MaxRetries + 1) : 1;
   localparam logic [CntW-1:0] WaitLast = CntW'(WaitCycles - 1);
   localparam logic [CntW-1:0] PulseLast = CntW'(PulseCycles - 1);
   localparam logic [CntW-1:0] ToLast = CntW'(RespTimeout - 1);
   localparam logic [RetW-1:0] RetMax = RetW'(MaxRetries);
   typedef enum logic [2:0] {IDLE, WAIT, REQ, RESP, WAKE, DONE, ERR} state_e;
   state_e state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d, tick;
   logic [RetW-1:0] ret_q, ret_d;
   logic [31:0] entry_q, entry_d;
   logic to, req;
   assign tick = (RespTimeout != 0) ? cnt_q + 1'b1 : cnt_q;
   assign to = (RespTimeout != 0) && (cnt_q >= ToLast);
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      ret_d = ret_q;
      entry_d = entry_q;
      case (state_q)
         IDLE, DONE, ERR: if (start_i) begin
            entry_d = entry_point_i;
            ret_d = '0;
            cnt_d = '0;
            state_d = |entry_point_i[1:0] ? ERR : (WaitCycles == 0 ? REQ : WAIT);
         end
         WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == WaitLast) begin
               cnt_d = '0;
               state_d = REQ;
            end
         end
         REQ: begin
            cnt_d = tick;
            state_d = q_ready_i ? RESP : (to ? ERR : REQ);
         end
         RESP: begin
            cnt_d = tick;
            if (p_valid_i) begin
               cnt_d = '0;
               if (!p_error_i) state_d = WAKE;
               else if (ret_q < RetMax) begin
                  ret_d = ret_q + 1'b1;
                  state_d = REQ;
               end else state_d = ERR;
            end else if (to) state_d = ERR;
         end
         WAKE: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == PulseLast) begin
               cnt_d = '0;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q <= '0;
         ret_q <= '0;
         entry_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         ret_q <= ret_d;
         entry_q <= entry_d;
      end
   end
   assign req = state_q == REQ;
   assign q_valid_o = req && !rst_i;
   assign q_write_o = req;
   assign q_addr_o = req ? BootCtrlAddr : '0;
   assign q_data_o = req ? DataWidth'(entry_q) : '0;
   assign q_strb_o = {(DataWidth/8){req}};
   assign p_ready_o = state_q == RESP;
   assign debug_req_o = {NumCores{state_q == WAKE}};
   assign busy_o = state_q inside {WAIT, REQ, RESP, WAKE};
   assign done_o = state_q == DONE;
   assign error_o = state_q == ERR;
endmodule

// File: doc/spatz_boot_sequencer.md
Name: spatz_boot_sequencer

Overview:
- Synthesizable boot master for the Spatz cluster.
- After start, it waits a programmable settle time, then writes the 32-bit entry point to the cluster peripheral boot-control register over a reqrsp master port. It then pulses debug_req to every core to wake them.
- Sits directly upstream of the reqrsp_to_axi converter that drives the cluster AXI slave port, and drives the cluster's debug_req input.

Parameters:
- AddrWidth, 48, reqrsp address width.
- DataWidth, 64, reqrsp data width; must be ≥32 and a multiple of 8.
- NumCores, 2, width of debug_req_o.
- BootCtrlAddr, 48'h0, byte address of the boot-control register (peripheral base + boot-control offset).
- WaitCycles, 1000, settle cycles between start and the write; 0 means no wait.
- PulseCycles, 1, debug_req_o high duration; must be ≥1.
- MaxRetries, 2, number of re-issues after an error response.
- RespTimeout, 4096, cycle limit from first q_valid to p_valid; 0 disables the limit.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  one-cycle start strobe
- entry_point_i  in  32  boot address, sampled on accepted start
- q_addr_o  out  AddrWidth  request address
- q_data_o  out  DataWidth  request write data
- q_strb_o  out  DataWidth/8  request byte strobes
- q_write_o  out  1  request is a write
- q_valid_o  out  1  request valid
- q_ready_i  in  1  request ready
- p_error_i  in  1  response error flag
- p_valid_i  in  1  response valid
- p_ready_o  out  1  response ready
- debug_req_o  out  NumCores  core wake-up pulse
- busy_o  out  1  sequence in progress
- done_o  out  1  sticky: boot completed
- error_o  out  1  sticky: boot failed

Behaviour:
- Reset: state IDLE. All outputs are 0, all counters are 0, and the latched entry point is 0. Reset mid-sequence aborts immediately; q_valid_o drops in the same cycle reset is sampled.
- States: IDLE, WAIT, REQ, RESP, WAKE, DONE, ERR. busy_o = state ∈ {WAIT, REQ, RESP, WAKE}.
- IDLE/DONE/ERR + start_i:
  - Latch entry_point_i.
  - Clear done_o, error_o and the retry count.
  - If entry_point_i[1:0] ≠ 0, go to ERR (misaligned).
  - Else if WaitCycles = 0, go to REQ; otherwise go to WAIT with the counter set to 0.
- start_i in any busy state is ignored.
- WAIT: counter increments each cycle. When counter = WaitCycles−1, go to REQ. Exact delay: q_valid_o first rises WaitCycles+1 cycles after the start cycle.
- REQ:
  - q_valid_o = 1, q_write_o = 1, q_addr_o = BootCtrlAddr.
  - q_data_o = zero-extended latched entry point; q_strb_o = all ones.
  - Payload is held stable while q_valid_o && !q_ready_i; valid is never withdrawn before the handshake.
  - On q_ready_i, go to RESP.
- RESP:
  - p_ready_o = 1. q_valid_o = 0 in RESP and in every state other than REQ.
  - On p_valid_i && !p_error_i, go to WAKE.
  - On p_valid_i && p_error_i: if retries < MaxRetries, increment retries and go to REQ; else go to ERR.
  - p_valid_i outside RESP is ignored; p_ready_o = 0 there.
- Timeout:
  - A counter runs in REQ and RESP, starting at the first REQ entry of each attempt.
  - If RespTimeout ≠ 0 and the counter reaches RespTimeout with no accepted response, go to ERR.
  - A response arriving in the same cycle as the timeout wins: the response is processed.
- WAKE: debug_req_o = all ones for exactly PulseCycles cycles, then go to DONE.
- DONE: done_o = 1 (sticky until the next accepted start or reset).
- ERR: error_o = 1 (sticky until the next accepted start or reset); debug_req_o is never asserted.
- Counter widths: sized with $clog2(max+1), so values never wrap.

Test Plan:
- Default params: start with entry 0x8000_0000, q_ready_i tied 1, p_valid_i returned 1 cycle after the handshake.
  - q_valid_o rises 1001 cycles after start with addr = BootCtrlAddr, data = 64'h0000_0000_8000_0000, strb = 8'hFF.
  - debug_req_o = 2'b11 for 1 cycle, then done_o = 1.
- Backpressure: q_ready_i held low for 7 cycles.
  - q_valid_o and the payload stay stable all 7 cycles; exactly one handshake occurs.
- Error retry: two error responses, then OK.
  - Three write handshakes, then the wake pulse and done_o = 1.
  - With three errors: error_o = 1 and debug_req_o stays 0.
- Misaligned entry 0x8000_0002: error_o = 1 one cycle after start; no q_valid_o is ever issued.
- Timeout with RespTimeout = 16 and no p_valid_i: error_o = 1 exactly 16 cycles after the first q_valid_o.
- Reset mid-RESP, then restart:
  - All outputs are 0 the cycle after reset.
  - A new start completes the normal sequence; a stale p_valid_i in IDLE is ignored.
